// File: rtl/residual_update_if.sv
// Bus between control_unit and residual_update_unit: pass control, row
// operands, result-row write port and the r.r result.
interface residual_update_if #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32,
  parameter int acc_width     = 72
);
  // Handshake: read_again_2 is a one-cycle request for the next R / A.P row;
  // there is no backpressure, so r_row/ap_row must be valid exactly one cycle
  // after each request, and result_mem_we_5 marks a result row that is valid
  // (and must be written) in that single cycle.
  logic                                 start;
  logic                                 halt;
  logic [31:0]                          total;
  logic [element_width-1:0]             alpha;
  logic [acc_width-1:0]                 tolerance;
  logic [no_of_units*element_width-1:0] r_row;
  logic [no_of_units*element_width-1:0] ap_row;
  logic                                 read_again_2;
  logic                                 result_mem_we_5;
  logic [31:0]                          result_mem_counter_5;
  logic [no_of_units*element_width-1:0] result_row;
  logic [acc_width-1:0]                 rr_sum;
  logic                                 busy;
  logic                                 done;
  logic                                 converged;

  modport master (
    output start, halt, total, alpha, tolerance, r_row, ap_row,
    input  read_again_2, result_mem_we_5, result_mem_counter_5, result_row,
           rr_sum, busy, done, converged
  );

  modport slave (
    input  start, halt, total, alpha, tolerance, r_row, ap_row,
    output read_again_2, result_mem_we_5, result_mem_counter_5, result_row,
           rr_sum, busy, done, converged
  );
endinterface

// File: rtl/residual_update_unit.sv
// CG residual update: r_new = r - alpha*Ap per lane, row by row, with a
// saturating r_new.r_new accumulator and a convergence flag.
module residual_update_unit #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32,
  parameter int frac_bits     = 16,
  parameter int acc_width     = 72
) (
  input  logic                 clk,
  input  logic                 reset,
  residual_update_if.slave     bus,
  output logic [1:0]           dbg_state
);
  localparam int EW = element_width;
  localparam int LW = no_of_units * element_width;
  localparam int SW = 2 * EW + $clog2(no_of_units) + 1;
  localparam logic [EW-1:0] SMAX = {1'b0, {(EW-1){1'b1}}};
  localparam logic [EW-1:0] SMIN = {1'b1, {(EW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, FINISH = 2'd3} state_t;

  state_t           state, state_nxt;
  logic             rd;
  logic [31:0]      rows_in, rows_q, issue_k, idx_s1;
  logic [EW-1:0]    alpha_q;
  logic             vld_s1;
  logic             we_q, busy_q, conv_q;
  logic [31:0]      cnt_q;
  logic [LW-1:0]    row_q, lane_res;
  logic [acc_width-1:0] rr_q;
  logic [acc_width:0]   acc_ext;
  logic [SW-1:0]        sum_sq;

  assign rows_in = bus.total / 32'(no_of_units);

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    case (state)
      IDLE:   if (bus.start) state_nxt = (rows_in == 32'd0) ? FINISH : READ;
      READ:   if (!bus.halt) begin
                rd = 1'b1;
                if (issue_k == rows_q - 32'd1) state_nxt = DRAIN;
              end
      DRAIN:  if (we_q && cnt_q == rows_q - 32'd1) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane datapath: operands arrive one cycle after the request and are
  // consumed straight from the memory ports into the result register.
  always_comb begin
    logic signed [2*EW-1:0] prod, prod_sh;
    logic [EW-1:0]          prod_sat, r_l, ap_l;
    logic [EW:0]            diff;
    lane_res = '0;
    prod = '0; prod_sh = '0; prod_sat = '0; r_l = '0; ap_l = '0; diff = '0;
    for (int i = 0; i < no_of_units; i++) begin
      r_l  = bus.r_row[i*EW +: EW];
      ap_l = bus.ap_row[i*EW +: EW];
      prod = $signed({{EW{alpha_q[EW-1]}}, alpha_q}) * $signed({{EW{ap_l[EW-1]}}, ap_l});
      prod_sh = prod >>> frac_bits;
      if (prod_sh[2*EW-1:EW-1] == {(EW+1){prod_sh[2*EW-1]}}) prod_sat = prod_sh[EW-1:0];
      else prod_sat = prod_sh[2*EW-1] ? SMIN : SMAX;
      diff = {r_l[EW-1], r_l} - {prod_sat[EW-1], prod_sat};
      if (diff[EW] == diff[EW-1]) lane_res[i*EW +: EW] = diff[EW-1:0];
      else lane_res[i*EW +: EW] = diff[EW] ? SMIN : SMAX;
    end
  end

  // Squares of the row being written; the sum can never exceed SW bits.
  always_comb begin
    logic signed [2*EW-1:0] d_ext;
    logic [2*EW-1:0]        sq;
    sum_sq = '0;
    d_ext  = '0;
    sq     = '0;
    for (int i = 0; i < no_of_units; i++) begin
      d_ext  = $signed({{EW{row_q[i*EW+EW-1]}}, row_q[i*EW +: EW]});
      sq     = d_ext * d_ext;
      sum_sq = sum_sq + {{(SW-2*EW){1'b0}}, sq};
    end
    acc_ext = {1'b0, rr_q} + {{(acc_width+1-SW){1'b0}}, sum_sq};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rows_q  <= '0;
      issue_k <= '0;
      idx_s1  <= '0;
      alpha_q <= '0;
      vld_s1  <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      row_q   <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_s1 <= rd;
      we_q   <= vld_s1;
      if (rd) begin
        idx_s1  <= issue_k;
        issue_k <= issue_k + 32'd1;
      end
      if (vld_s1) begin
        cnt_q <= idx_s1;
        row_q <= lane_res;
      end
      if (we_q) rr_q <= acc_ext[acc_width] ? {acc_width{1'b1}} : acc_ext[acc_width-1:0];
      if (state == IDLE && bus.start) begin
        alpha_q <= bus.alpha;
        rows_q  <= rows_in;
        issue_k <= '0;
        rr_q    <= '0;
        conv_q  <= 1'b0;
        busy_q  <= 1'b1;
      end
      if (state == FINISH) begin
        conv_q <= (rr_q < bus.tolerance);
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.read_again_2         = rd;
  assign bus.done                 = (state == FINISH);
  assign bus.result_mem_we_5      = we_q;
  assign bus.result_mem_counter_5 = cnt_q;
  assign bus.result_row           = row_q;
  assign bus.rr_sum               = rr_q;
  assign bus.busy                 = busy_q;
  assign bus.converged            = conv_q;
  assign dbg_state                = state;
endmodule
